// File: rtl/bus_cycle_arbiter_n_if.sv
// rtl/bus_cycle_arbiter_n_if.sv - request/grant bundle between requesters and the ND100 bus cycle arbiter
interface bus_cycle_arbiter_n_if #(
    parameter int NUM_DMA = 4,
    parameter int ID_W    = (NUM_DMA > 1) ? $clog2(NUM_DMA) : 1
);
    logic               CRQ;
    logic               IORQ;
    logic               REFRQ;
    logic [NUM_DMA-1:0] BRQ;
    logic               SEMRQ;
    logic               BDRY;
    logic               CACT;
    logic               REF;
    logic [NUM_DMA-1:0] GNT;
    logic [ID_W-1:0]    GNT_ID;
    logic               IOD;
    logic               MEM;
    logic               ACT;
    logic               DOREF;
    logic               SEM;
    logic               TMO;

    // master is the arbiter side: it owns the bus cycle and drives the grants
    modport master (
        input  CRQ, IORQ, REFRQ, BRQ, SEMRQ, BDRY,
        output CACT, REF, GNT, GNT_ID, IOD, MEM, ACT, DOREF, SEM, TMO
    );

    modport slave (
        output CRQ, IORQ, REFRQ, BRQ, SEMRQ, BDRY,
        input  CACT, REF, GNT, GNT_ID, IOD, MEM, ACT, DOREF, SEM, TMO
    );
endinterface

// File: rtl/bus_cycle_arbiter_n.sv
// rtl/bus_cycle_arbiter_n.sv - ND100 bus cycle arbiter (refresh/CPU/DMA, semaphore lock); optional watchdog via BUS_TIMEOUT_EN
module bus_cycle_arbiter_n #(
    parameter int NUM_DMA        = 4,
    parameter int RR_EN          = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CK,
    input  logic                  MR,
    bus_cycle_arbiter_n_if.master bus
);
    localparam int ID_W = (NUM_DMA > 1) ? $clog2(NUM_DMA) : 1;

    typedef enum logic [1:0] {IDLE, CPU, RFSH, DMA} state_t;

    state_t             state_q, state_d;
    logic               cact_q, cact_d;
    logic               ref_q, ref_d;
    logic [NUM_DMA-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic               iod_q, iod_d;
    logic               mem_q, mem_d;
    logic               act_q;
    logic               doref_q, doref_d;
    logic               sem_q, sem_d;
    logic               sem_cpu_q, sem_cpu_d;
    logic [ID_W-1:0]    sem_id_q, sem_id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               grant;
    logic               tmo_hit;

    logic [NUM_DMA-1:0] dma_ok;
    logic               cpu_ok;
    logic               ref_ok;
    logic               found;
    logic [ID_W-1:0]    pick;
    logic [ID_W:0]      sum;

    // While locked, only the semaphore owner may win; refresh is held off entirely
    always_comb begin
        cpu_ok = bus.CRQ && (!sem_q || sem_cpu_q);
        ref_ok = bus.REFRQ && !sem_q;
        dma_ok = '0;
        for (int i = 0; i < NUM_DMA; i++) begin
            dma_ok[i] = bus.BRQ[i] && (!sem_q || (!sem_cpu_q && sem_id_q == ID_W'(i)));
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int k = 0; k < NUM_DMA; k++) begin
            if (RR_EN != 0) begin
                sum = {1'b0, ptr_q} + (ID_W+1)'(k);
                if (sum >= (ID_W+1)'(NUM_DMA)) begin
                    sum = sum - (ID_W+1)'(NUM_DMA);
                end
            end else begin
                sum = (ID_W+1)'(k);
            end
            if (!found && dma_ok[sum[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cact_d    = cact_q;
        ref_d     = ref_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        iod_d     = iod_q;
        mem_d     = mem_q;
        doref_d   = doref_q;
        sem_d     = sem_q;
        sem_cpu_d = sem_cpu_q;
        sem_id_d  = sem_id_q;
        ptr_d     = ptr_q;
        grant     = 1'b0;
        if (state_q == IDLE) begin
            if (!bus.BDRY) begin
                if (ref_ok) begin
                    state_d = RFSH;
                    ref_d   = 1'b1;
                    mem_d   = 1'b1;
                    iod_d   = 1'b0;
                    grant   = 1'b1;
                end else if (cpu_ok && (doref_q || !found)) begin
                    state_d = CPU;
                    cact_d  = 1'b1;
                    iod_d   = bus.IORQ;
                    mem_d   = !bus.IORQ;
                    doref_d = 1'b0;
                    grant   = 1'b1;
                end else if (found) begin
                    state_d      = DMA;
                    gnt_d        = '0;
                    gnt_d[pick]  = 1'b1;
                    gnt_id_d     = pick;
                    mem_d        = 1'b1;
                    iod_d        = 1'b0;
                    doref_d      = 1'b0;
                    grant        = 1'b1;
                    ptr_d        = (pick == ID_W'(NUM_DMA-1)) ? '0 : pick + 1'b1;
                end
            end
        end else if (bus.BDRY || tmo_hit) begin
            state_d  = IDLE;
            cact_d   = 1'b0;
            ref_d    = 1'b0;
            gnt_d    = '0;
            gnt_id_d = '0;
            iod_d    = 1'b0;
            mem_d    = 1'b0;
            if (state_q == RFSH) begin
                doref_d = 1'b1;
            end
            if (tmo_hit) begin
                sem_d = 1'b0;
            end else if (state_q != RFSH) begin
                // Any CPU/DMA cycle ending while locked belongs to the owner
                sem_d = bus.SEMRQ;
                if (bus.SEMRQ) begin
                    sem_cpu_d = (state_q == CPU);
                    sem_id_d  = gnt_id_q;
                end
            end
        end
    end

    always_ff @(posedge CK) begin
        if (MR) begin
            state_q   <= bus.REFRQ ? RFSH : IDLE;
            cact_q    <= 1'b0;
            ref_q     <= bus.REFRQ;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            iod_q     <= 1'b0;
            mem_q     <= bus.REFRQ;
            act_q     <= bus.REFRQ;
            doref_q   <= 1'b0;
            sem_q     <= 1'b0;
            sem_cpu_q <= 1'b0;
            sem_id_q  <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            cact_q    <= cact_d;
            ref_q     <= ref_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            iod_q     <= iod_d;
            mem_q     <= mem_d;
            act_q     <= (state_d != IDLE);
            doref_q   <= doref_d;
            sem_q     <= sem_d;
            sem_cpu_q <= sem_cpu_d;
            sem_id_q  <= sem_id_d;
            ptr_q     <= ptr_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt_q;
    logic          tmo_q;

    assign tmo_hit = (state_q != IDLE) && !bus.BDRY && (wd_cnt_q == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge CK) begin
        if (MR) begin
            wd_cnt_q <= '0;
            tmo_q    <= 1'b0;
        end else begin
            tmo_q <= tmo_hit;
            if (grant) begin
                wd_cnt_q <= '0;
            end else if (act_q && wd_cnt_q != CW'(TIMEOUT_CYCLES)) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
        end
    end

    assign bus.TMO = tmo_q;
`else
    assign tmo_hit = 1'b0;
    assign bus.TMO = 1'b0;
`endif

    assign bus.CACT   = cact_q;
    assign bus.REF    = ref_q;
    assign bus.GNT    = gnt_q;
    assign bus.GNT_ID = gnt_id_q;
    assign bus.IOD    = iod_q;
    assign bus.MEM    = mem_q;
    assign bus.ACT    = act_q;
    assign bus.DOREF  = doref_q;
    assign bus.SEM    = sem_q;
endmodule

// File: tb/tb_bus_cycle_arbiter_n.sv
// tb/tb_bus_cycle_arbiter_n.sv - directed self-checking bench for bus_cycle_arbiter_n (round-robin and fixed instances)
module tb_bus_cycle_arbiter_n;
    logic CK = 1'b0;
    logic MR;
    int   checks = 0;
    int   errors = 0;

    always #5 CK = ~CK;

    bus_cycle_arbiter_n_if #(.NUM_DMA(4)) bi ();
    bus_cycle_arbiter_n_if #(.NUM_DMA(4)) bf ();

    // The fixed-priority instance sees exactly the same requests
    assign bf.CRQ   = bi.CRQ;
    assign bf.IORQ  = bi.IORQ;
    assign bf.REFRQ = bi.REFRQ;
    assign bf.BRQ   = bi.BRQ;
    assign bf.SEMRQ = bi.SEMRQ;
    assign bf.BDRY  = bi.BDRY;

    bus_cycle_arbiter_n #(.NUM_DMA(4), .RR_EN(1), .TIMEOUT_CYCLES(8)) dut_rr (
        .CK  (CK),
        .MR  (MR),
        .bus (bi)
    );

    bus_cycle_arbiter_n #(.NUM_DMA(4), .RR_EN(0), .TIMEOUT_CYCLES(8)) dut_fx (
        .CK  (CK),
        .MR  (MR),
        .bus (bf)
    );

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] e_gnt;
        int         rr_order [4];
        rr_order = '{0, 1, 3, 0};

        MR = 1'b1;
        bi.CRQ = 1'b0; bi.IORQ = 1'b0; bi.REFRQ = 1'b1;
        bi.BRQ = 4'b0000; bi.SEMRQ = 1'b0; bi.BDRY = 1'b0;
        repeat (3) tick();
        chk("rst_ref",   32'(bi.REF),   32'd1);
        chk("rst_mem",   32'(bi.MEM),   32'd1);
        chk("rst_cact",  32'(bi.CACT),  32'd0);
        chk("rst_gnt",   32'(bi.GNT),   32'd0);
        chk("rst_iod",   32'(bi.IOD),   32'd0);
        chk("rst_doref", 32'(bi.DOREF), 32'd0);
        chk("rst_sem",   32'(bi.SEM),   32'd0);
        chk("rst_tmo",   32'(bi.TMO),   32'd0);

        MR = 1'b0; bi.REFRQ = 1'b0;
        tick();
        chk("post_rst_ref_held", 32'(bi.REF), 32'd1);
        bi.BDRY = 1'b1;
        tick();
        bi.BDRY = 1'b0;
        chk("rst_ref_end_ref",   32'(bi.REF),   32'd0);
        chk("rst_ref_end_mem",   32'(bi.MEM),   32'd0);
        chk("rst_ref_end_act",   32'(bi.ACT),   32'd0);
        chk("rst_ref_end_doref", 32'(bi.DOREF), 32'd1);

        // Refresh, CPU and DMA all requesting at once
        bi.REFRQ = 1'b1; bi.CRQ = 1'b1; bi.BRQ = 4'b0010;
        tick();
        chk("mix_ref",  32'(bi.REF),  32'd1);
        chk("mix_cact", 32'(bi.CACT), 32'd0);
        chk("mix_gnt",  32'(bi.GNT),  32'd0);
        bi.REFRQ = 1'b0; bi.BDRY = 1'b1;
        tick();
        bi.BDRY = 1'b0;
        chk("mix_ref_end",   32'(bi.REF),   32'd0);
        chk("mix_doref_set", 32'(bi.DOREF), 32'd1);
        tick();
        chk("mix_cpu_cact",   32'(bi.CACT),  32'd1);
        chk("mix_cpu_gnt",    32'(bi.GNT),   32'd0);
        chk("mix_cpu_doref",  32'(bi.DOREF), 32'd0);
        chk("mix_cpu_mem",    32'(bi.MEM),   32'd1);
        bi.CRQ = 1'b0; bi.BDRY = 1'b1;
        tick();
        bi.BDRY = 1'b0;
        chk("mix_cpu_end", 32'(bi.ACT), 32'd0);
        tick();
        chk("mix_dma_gnt",    32'(bi.GNT),    32'h2);
        chk("mix_dma_id",     32'(bi.GNT_ID), 32'd1);
        chk("mix_dma_fx_gnt", 32'(bf.GNT),    32'h2);
        chk("mix_dma_mem",    32'(bi.MEM),    32'd1);
        bi.BRQ = 4'b0000; bi.BDRY = 1'b1;
        tick();
        bi.BDRY = 1'b0;
        chk("mix_dma_end", 32'(bi.GNT), 32'd0);

        // Reset clears the round-robin pointer
        MR = 1'b1;
        tick();
        MR = 1'b0;
        bi.BRQ = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            tick();
            e_gnt = 4'b0001 << rr_order[i];
            chk("rr_id",  32'(bi.GNT_ID), 32'(rr_order[i]));
            chk("rr_gnt", 32'(bi.GNT),    32'(e_gnt));
            chk("fx_id",  32'(bf.GNT_ID), 32'd0);
            bi.BDRY = 1'b1;
            tick();
            bi.BDRY = 1'b0;
            chk("rr_idle", 32'(bi.ACT), 32'd0);
        end
        bi.BRQ = 4'b0000;

        // CPU IO cycle; IORQ changes mid-cycle must not leak through
        bi.CRQ = 1'b1; bi.IORQ = 1'b1;
        tick();
        chk("io_cact", 32'(bi.CACT), 32'd1);
        chk("io_iod",  32'(bi.IOD),  32'd1);
        chk("io_mem",  32'(bi.MEM),  32'd0);
        bi.CRQ = 1'b0; bi.IORQ = 1'b0;
        tick();
        chk("io_hold_cact", 32'(bi.CACT), 32'd1);
        chk("io_hold_iod",  32'(bi.IOD),  32'd1);
        chk("io_hold_mem",  32'(bi.MEM),  32'd0);
        bi.BDRY = 1'b1;
        tick();
        bi.BDRY = 1'b0;
        chk("io_end_iod",  32'(bi.IOD),  32'd0);
        chk("io_end_mem",  32'(bi.MEM),  32'd0);
        chk("io_end_cact", 32'(bi.CACT), 32'd0);

        // Semaphore owned by DMA 2
        bi.BRQ = 4'b0100;
        tick();
        chk("sem_dma_id", 32'(bi.GNT_ID), 32'd2);
        bi.BRQ = 4'b0000; bi.SEMRQ = 1'b1; bi.BDRY = 1'b1;
        tick();
        bi.SEMRQ = 1'b0; bi.BDRY = 1'b0;
        chk("sem_set",    32'(bi.SEM), 32'd1);
        chk("sem_fx_set", 32'(bf.SEM), 32'd1);
        bi.REFRQ = 1'b1; bi.CRQ = 1'b1; bi.BRQ = 4'b0001;
        repeat (2) tick();
        chk("sem_block_act",    32'(bi.ACT), 32'd0);
        chk("sem_block_fx_act", 32'(bf.ACT), 32'd0);
        bi.BRQ = 4'b0101;
        tick();
        chk("sem_owner_gnt",    32'(bi.GNT), 32'h4);
        chk("sem_owner_fx_gnt", 32'(bf.GNT), 32'h4);
        bi.BRQ = 4'b0000; bi.BDRY = 1'b1;
        tick();
        bi.BDRY = 1'b0;
        chk("sem_clear", 32'(bi.SEM), 32'd0);
        chk("sem_clear_act", 32'(bi.ACT), 32'd0);
        tick();
        chk("sem_then_ref", 32'(bi.REF), 32'd1);
        bi.REFRQ = 1'b0; bi.CRQ = 1'b0; bi.BDRY = 1'b1;
        tick();
        bi.BDRY = 1'b0;
        chk("sem_ref_doref", 32'(bi.DOREF), 32'd1);

        // Long CPU cycle with no BDRY
        bi.CRQ = 1'b1;
        tick();
        bi.CRQ = 1'b0;
        chk("wd_grant", 32'(bi.CACT), 32'd1);
`ifdef BUS_TIMEOUT_EN
        repeat (8) tick();
        chk("wd_pre_cact", 32'(bi.CACT), 32'd1);
        chk("wd_pre_tmo",  32'(bi.TMO),  32'd0);
        tick();
        chk("wd_abort_cact", 32'(bi.CACT), 32'd0);
        chk("wd_abort_tmo",  32'(bi.TMO),  32'd1);
        tick();
        chk("wd_tmo_pulse", 32'(bi.TMO), 32'd0);
`else
        repeat (20) tick();
        chk("wd_off_cact", 32'(bi.CACT), 32'd1);
        chk("wd_off_tmo",  32'(bi.TMO),  32'd0);
        bi.BDRY = 1'b1;
        tick();
        bi.BDRY = 1'b0;
        chk("wd_off_end", 32'(bi.CACT), 32'd0);
`endif

        // Master reset in the middle of a CPU cycle
        bi.CRQ = 1'b1;
        tick();
        chk("mr_mid_grant", 32'(bi.CACT), 32'd1);
        bi.CRQ = 1'b0; MR = 1'b1;
        tick();
        MR = 1'b0;
        chk("mr_mid_cact", 32'(bi.CACT), 32'd0);
        chk("mr_mid_act",  32'(bi.ACT),  32'd0);
        chk("mr_mid_mem",  32'(bi.MEM),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
